// File: rtl/sgmii_pkg.sv
// Shared SGMII auto-negotiation constants: code groups, config word bits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sgmii_pkg;

    // Code groups used to frame /C/ and /I/ ordered sets
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D2_2  = 8'h42;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    // Config word as sent by the MAC side, and the acknowledge bit position
    localparam logic [15:0] SGMII_CFG_ABIL    = 16'h0001;
    localparam int          SGMII_CFG_ACK_BIT = 14;
    localparam logic [15:0] SGMII_ACK_MASK    = 16'h0001 << SGMII_CFG_ACK_BIT;

    // Condensed Clause-37 / SGMII arbitration states
    typedef enum logic [2:0] {
        AN_RESTART        = 3'd0,
        AN_ABILITY_DETECT = 3'd1,
        AN_ACK_DETECT     = 3'd2,
        AN_COMPLETE_ACK   = 3'd3,
        AN_IDLE_DETECT    = 3'd4,
        AN_LINK_OK        = 3'd5
    } an_state_e;

endpackage

// File: rtl/sgmii_os_parse.sv
// Ordered-set parser: recognises /C/ config words and /I/ idles in the decoded TBI byte stream.
// Latency: cfg_valid/idle_valid are registered, high the cycle after the final byte of the set.
// Backpressure: none; one byte consumed every cycle, pulses are single-cycle.
module sgmii_os_parse
    import sgmii_pkg::*;
(
    input  logic        clk_125mhz,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_is_k,
    output logic        cfg_valid,
    output logic [15:0] cfg_word,
    output logic        idle_valid
);

    localparam logic [1:0] PS_HUNT = 2'd0;
    localparam logic [1:0] PS_K    = 2'd1;
    localparam logic [1:0] PS_LO   = 2'd2;
    localparam logic [1:0] PS_HI   = 2'd3;

    logic [1:0] pst;
    logic [7:0] lo_byte;

    // Walk K28.5 -> qualifier -> low -> high; any K restarts (K28.5) or aborts (other K)
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            pst        <= PS_HUNT;
            lo_byte    <= 8'h00;
            cfg_word   <= 16'h0000;
            cfg_valid  <= 1'b0;
            idle_valid <= 1'b0;
        end else begin
            cfg_valid  <= 1'b0;
            idle_valid <= 1'b0;
            if (rx_is_k) begin
                pst <= (rx_byte == K28_5) ? PS_K : PS_HUNT;
            end else begin
                case (pst)
                    PS_K: begin
                        if (rx_byte == D21_5 || rx_byte == D2_2) begin
                            pst <= PS_LO;
                        end else begin
                            pst <= PS_HUNT;
                            if (rx_byte == D5_6 || rx_byte == D16_2) begin
                                idle_valid <= 1'b1;
                            end
                        end
                    end
                    PS_LO: begin
                        lo_byte <= rx_byte;
                        pst     <= PS_HI;
                    end
                    PS_HI: begin
                        cfg_word  <= {rx_byte, lo_byte};
                        cfg_valid <= 1'b1;
                        pst       <= PS_HUNT;
                    end
                    default: pst <= PS_HUNT;
                endcase
            end
        end
    end

endmodule

// File: rtl/sgmii_autoneg.sv
// SGMII auto-negotiation sequencer (MAC side): FSM, word match tracking, link timer.
// Latency: last byte of a decisive word at N -> new state and outputs at N+2; outputs decode from state.
// Backpressure: none; RX stream is consumed every cycle, TX encoder just samples tx_cfg_en/tx_cfg_reg.
module sgmii_autoneg
    import sgmii_pkg::*;
#(
    parameter int LINK_TIMER = 200000
) (
    input  logic        clk_125mhz,
    input  logic        rst,
    input  logic        rx_sync,
    input  logic [7:0]  rx_byte,
    input  logic        rx_is_k,
    input  logic        mr_restart,
    output logic        tx_cfg_en,
    output logic [15:0] tx_cfg_reg,
    output logic        sgmii_autoneg_done,
    output logic [1:0]  link_speed,
    output logic        link_duplex,
    output logic        link_up
);

    localparam int            TW         = $clog2(LINK_TIMER);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LINK_TIMER - 1);

    logic        cfg_valid;
    logic [15:0] cfg_word;
    logic        idle_valid;

    sgmii_os_parse u_parse (
        .clk_125mhz (clk_125mhz),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_is_k    (rx_is_k),
        .cfg_valid  (cfg_valid),
        .cfg_word   (cfg_word),
        .idle_valid (idle_valid)
    );

    an_state_e   state, state_nxt;
    logic [TW-1:0] timer;
    logic [1:0]  match_cnt, match_nxt;
    logic [15:0] prev_m;
    logic [15:0] ability;
    logic [1:0]  ack_cnt;
    logic [1:0]  idle_cnt;

    logic        restart;
    logic        timer_exp;
    logic [15:0] word_m;
    logic        word_zero;
    logic        abil_match;
    logic        idle_hit;
    logic        state_entry;

    assign restart     = !rx_sync || mr_restart;
    assign timer_exp   = (timer == TIMER_LAST);
    assign word_m      = cfg_word & ~SGMII_ACK_MASK;
    assign word_zero   = (cfg_word == 16'h0000);
    assign abil_match  = (word_m == ability);
    // Third idle may arrive in the same cycle the timer expires
    assign idle_hit    = (idle_cnt == 2'd3) || (idle_cnt == 2'd2 && idle_valid);
    assign state_entry = restart || (state_nxt != state);

    // Consecutive-match count for the incoming word (ack bit ignored)
    always_comb begin
        match_nxt = match_cnt;
        if (cfg_valid) begin
            if (word_zero)
                match_nxt = 2'd0;
            else if (word_m == prev_m)
                match_nxt = (match_cnt == 2'd3) ? 2'd3 : match_cnt + 2'd1;
            else
                match_nxt = 2'd1;
        end
    end

    // Next-state: restarts first, then word-driven exits ahead of timer exits
    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = AN_RESTART;
        end else begin
            case (state)
                AN_RESTART:
                    if (timer_exp) state_nxt = AN_ABILITY_DETECT;
                AN_ABILITY_DETECT:
                    if (cfg_valid && !word_zero && match_nxt == 2'd3) state_nxt = AN_ACK_DETECT;
                AN_ACK_DETECT:
                    if (cfg_valid) begin
                        if (word_zero)
                            state_nxt = AN_RESTART;
                        else if (!abil_match)
                            state_nxt = AN_ABILITY_DETECT;
                        else if (cfg_word[SGMII_CFG_ACK_BIT] && ack_cnt == 2'd2)
                            state_nxt = AN_COMPLETE_ACK;
                    end
                AN_COMPLETE_ACK:
                    if (cfg_valid && word_zero)
                        state_nxt = AN_RESTART;
                    else if (cfg_valid && !abil_match)
                        state_nxt = AN_ABILITY_DETECT;
                    else if (timer_exp)
                        state_nxt = AN_IDLE_DETECT;
                AN_IDLE_DETECT:
                    if (cfg_valid)
                        state_nxt = AN_RESTART;
                    else if (timer_exp && idle_hit)
                        state_nxt = AN_LINK_OK;
                AN_LINK_OK:
                    if (cfg_valid) state_nxt = AN_RESTART;
                default: state_nxt = AN_RESTART;
            endcase
        end
    end

    // State, link timer and per-state event counters
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            state     <= AN_RESTART;
            timer     <= '0;
            match_cnt <= 2'd0;
            prev_m    <= 16'h0000;
            ack_cnt   <= 2'd0;
            idle_cnt  <= 2'd0;
        end else begin
            state     <= state_nxt;
            match_cnt <= restart ? 2'd0 : match_nxt;
            if (cfg_valid)
                prev_m <= word_m;
            if (state_entry)
                timer <= '0;
            else if (!timer_exp)
                timer <= timer + 1'b1;
            if (state_entry)
                ack_cnt <= 2'd0;
            else if (state == AN_ACK_DETECT && cfg_valid)
                ack_cnt <= cfg_word[SGMII_CFG_ACK_BIT] ? ack_cnt + 2'd1 : 2'd0;
            if (state_entry || cfg_valid)
                idle_cnt <= 2'd0;
            else if (idle_valid && idle_cnt != 2'd3)
                idle_cnt <= idle_cnt + 2'd1;
        end
    end

    // Capture the partner ability and publish it when the link comes up
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            ability     <= 16'h0000;
            link_speed  <= 2'b00;
            link_duplex <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            if (state == AN_ABILITY_DETECT && state_nxt == AN_ACK_DETECT)
                ability <= word_m;
            if (state != AN_LINK_OK && state_nxt == AN_LINK_OK) begin
                link_speed  <= ability[11:10];
                link_duplex <= ability[12];
                link_up     <= ability[15];
            end
        end
    end

    // Outputs decode straight from the state register
    always_comb begin
        tx_cfg_en          = 1'b1;
        tx_cfg_reg         = SGMII_CFG_ABIL | SGMII_ACK_MASK;
        sgmii_autoneg_done = 1'b0;
        case (state)
            AN_RESTART:        tx_cfg_reg = 16'h0000;
            AN_ABILITY_DETECT: tx_cfg_reg = SGMII_CFG_ABIL;
            AN_IDLE_DETECT:    tx_cfg_en  = 1'b0;
            AN_LINK_OK: begin
                tx_cfg_en          = 1'b0;
                sgmii_autoneg_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sgmii_autoneg.sv
// Directed bench for sgmii_autoneg with a short link timer.
// Latency: inputs driven on negedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_sgmii_autoneg;

    logic        clk_125mhz = 1'b0;
    logic        rst;
    logic        rx_sync;
    logic [7:0]  rx_byte;
    logic        rx_is_k;
    logic        mr_restart;
    logic        tx_cfg_en;
    logic [15:0] tx_cfg_reg;
    logic        sgmii_autoneg_done;
    logic [1:0]  link_speed;
    logic        link_duplex;
    logic        link_up;

    int n_chk  = 0;
    int n_pass = 0;
    int cfg_seen = 0;

    sgmii_autoneg #(.LINK_TIMER(16)) dut (
        .clk_125mhz         (clk_125mhz),
        .rst                (rst),
        .rx_sync            (rx_sync),
        .rx_byte            (rx_byte),
        .rx_is_k            (rx_is_k),
        .mr_restart         (mr_restart),
        .tx_cfg_en          (tx_cfg_en),
        .tx_cfg_reg         (tx_cfg_reg),
        .sgmii_autoneg_done (sgmii_autoneg_done),
        .link_speed         (link_speed),
        .link_duplex        (link_duplex),
        .link_up            (link_up)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    // Count parser config pulses so aborted sets can be shown to emit nothing
    always @(posedge clk_125mhz) begin
        if (dut.cfg_valid === 1'b1) cfg_seen++;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_125mhz);
    endtask

    task automatic put(input logic k, input logic [7:0] b);
        rx_is_k = k;
        rx_byte = b;
        @(negedge clk_125mhz);
    endtask

    task automatic quiet();
        rx_is_k = 1'b0;
        rx_byte = 8'h00;
    endtask

    // Returns in the cycle cfg_valid is high for this word
    task automatic send_cfg(input logic [15:0] w, input bit alt);
        put(1'b1, 8'hBC);
        put(1'b0, alt ? 8'h42 : 8'hB5);
        put(1'b0, w[7:0]);
        put(1'b0, w[15:8]);
        quiet();
    endtask

    task automatic send_idle(input bit alt);
        put(1'b1, 8'hBC);
        put(1'b0, alt ? 8'h50 : 8'hC5);
        quiet();
    endtask

    // From ABILITY_DETECT cycle: full handshake through to LINK_OK
    task automatic do_link(input logic [15:0] w_abil, input logic [15:0] w_ack);
        for (int i = 0; i < 3; i++) send_cfg(w_abil, i[0]);
        cyc(1);
        chk("abil_to_ack", tx_cfg_reg, 16'h4001);
        for (int i = 0; i < 3; i++) send_cfg(w_ack, i[0]);
        cyc(1);
        cyc(15);
        chk("cack_cfg_en_hold", {15'd0, tx_cfg_en}, 16'd1);
        cyc(1);
        chk("cack_cfg_en_drop", {15'd0, tx_cfg_en}, 16'd0);
        for (int i = 0; i < 3; i++) send_idle(i[0]);
        chk("idle_early_done", {15'd0, sgmii_autoneg_done}, 16'd0);
        cyc(9);
        chk("idle_timer_done", {15'd0, sgmii_autoneg_done}, 16'd0);
        cyc(1);
        chk("link_ok_done", {15'd0, sgmii_autoneg_done}, 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        rst = 1'b1; rx_sync = 1'b1; mr_restart = 1'b0;
        quiet();
        cyc(3);
        chk("rst_cfg_en",  {15'd0, tx_cfg_en}, 16'd1);
        chk("rst_cfg_reg", tx_cfg_reg, 16'h0000);
        chk("rst_done",    {15'd0, sgmii_autoneg_done}, 16'd0);
        chk("rst_link",    {12'd0, link_speed, link_duplex, link_up}, 16'd0);
        chk("rst_match",   {14'd0, dut.match_cnt}, 16'd0);
        rst = 1'b0;

        // RESTART holds exactly 16 cycles
        for (int i = 0; i < 16; i++) begin
            chk("restart_hold", tx_cfg_reg, 16'h0000);
            cyc(1);
        end
        chk("restart_exit", tx_cfg_reg, 16'h0001);

        // Mismatching word resets the count; two more matches complete it
        send_cfg(16'hD801, 1'b0);
        send_cfg(16'hD801, 1'b1);
        send_cfg(16'h9401, 1'b0);
        cyc(1);
        chk("mis_no_move", tx_cfg_reg, 16'h0001);
        chk("mis_match",   {14'd0, dut.match_cnt}, 16'd1);
        send_cfg(16'h9401, 1'b1);
        send_cfg(16'h9401, 1'b0);
        chk("mis_latency", tx_cfg_reg, 16'h0001);
        cyc(1);
        chk("mis_to_ack",  tx_cfg_reg, 16'h4001);
        chk("mis_ability", dut.ability, 16'h9401);

        // Zero word in ACK_DETECT
        send_cfg(16'h0000, 1'b0);
        chk("zero_latency", tx_cfg_reg, 16'h4001);
        cyc(1);
        chk("zero_restart", tx_cfg_reg, 16'h0000);
        cyc(16);
        chk("zero_reabil", tx_cfg_reg, 16'h0001);

        // Full handshake: 1G, full duplex, link up
        do_link(16'hD801, 16'hD801);
        chk("hs1_speed",  {14'd0, link_speed}, 16'd2);
        chk("hs1_duplex", {15'd0, link_duplex}, 16'd1);
        chk("hs1_up",     {15'd0, link_up}, 16'd1);

        // Single-cycle sync loss
        rx_sync = 1'b0;
        cyc(1);
        rx_sync = 1'b1;
        chk("sync_drop_done", {15'd0, sgmii_autoneg_done}, 16'd0);
        chk("sync_drop_reg",  tx_cfg_reg, 16'h0000);
        chk("speed_hold",     {14'd0, link_speed}, 16'd2);
        cyc(16);

        // Second handshake: 10M, half duplex, link up
        do_link(16'h8001, 16'hC001);
        chk("hs2_speed",  {14'd0, link_speed}, 16'd0);
        chk("hs2_duplex", {15'd0, link_duplex}, 16'd0);
        chk("hs2_up",     {15'd0, link_up}, 16'd1);

        // Config word while link is up
        send_cfg(16'hC001, 1'b1);
        chk("inject_latency", {15'd0, sgmii_autoneg_done}, 16'd1);
        cyc(1);
        chk("inject_done",   {15'd0, sgmii_autoneg_done}, 16'd0);
        chk("inject_cfg_en", {15'd0, tx_cfg_en}, 16'd1);
        chk("inject_reg",    tx_cfg_reg, 16'h0000);
        cyc(16);

        // Parser abort leaves the match count alone
        send_cfg(16'h9401, 1'b0);
        send_cfg(16'h9401, 1'b1);
        cyc(1);
        s0 = cfg_seen;
        put(1'b1, 8'hBC);
        put(1'b0, 8'hB5);
        put(1'b1, 8'h3C);
        put(1'b0, 8'h12);
        put(1'b0, 8'h34);
        quiet();
        cyc(2);
        chk("abort_no_cfg", 16'(cfg_seen - s0), 16'd0);
        chk("abort_match",  {14'd0, dut.match_cnt}, 16'd2);
        chk("abort_state",  tx_cfg_reg, 16'h0001);
        send_cfg(16'h9401, 1'b0);
        cyc(1);
        chk("abort_resume", tx_cfg_reg, 16'h4001);

        // Ability mismatch in ACK_DETECT falls back
        send_cfg(16'h8001, 1'b0);
        cyc(1);
        chk("ack_mis_back", tx_cfg_reg, 16'h0001);
        for (int i = 0; i < 2; i++) send_cfg(16'h8001, i[0]);
        cyc(1);
        chk("ack_mis_reack", tx_cfg_reg, 16'h4001);

        // Management restart
        mr_restart = 1'b1;
        cyc(1);
        mr_restart = 1'b0;
        chk("mr_restart", tx_cfg_reg, 16'h0000);
        chk("mr_match",   {14'd0, dut.match_cnt}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sgmii_autoneg.md
# sgmii_autoneg

Sequences SGMII auto-negotiation on the MAC side of the TBI link, in the `clk_125mhz` domain. It parses received /C/ and /I/ ordered sets, runs a condensed Clause-37/SGMII state machine, and drives the TX encoder's config-word request. It produces `sgmii_autoneg_done`, which gates the SGMII RX buffer and packet path, plus the PHY-advertised speed, duplex and link status.

## Interface

- `LINK_TIMER`, default 200000: link-timer length in `clk_125mhz` cycles (1.6 ms). Minimum 4.
- `clk_125mhz` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_sync` in 1: PCS code-group sync, already in the `clk_125mhz` domain. Low forces restart.
- `rx_byte` in 8: decoded RX byte, one per cycle.
- `rx_is_k` in 1: `rx_byte` is a K character.
- `mr_restart` in 1: single-cycle request to renegotiate.
- `tx_cfg_en` out 1: TX encoder sends /C/ ordered sets when 1 and /I/ when 0.
- `tx_cfg_reg` out 16: config word the TX encoder sends.
- `sgmii_autoneg_done` out 1: link negotiated; RX/TX datapath enabled.
- `link_speed` out 2: latched PHY ability bits [11:10]: 00 = 10M, 01 = 100M, 10 = 1G.
- `link_duplex` out 1: latched PHY ability bit 12.
- `link_up` out 1: latched PHY ability bit 15.

## Operation

- **Parser**
  - K28.5 (0xBC, K) followed by data 0xB5 or 0x42 → the next two data bytes are the config word, low byte then high byte. Emits a `cfg_valid` pulse with `cfg_word`.
  - K28.5 followed by data 0xC5 or 0x50 → `idle_valid` pulse.
  - A K character or K28.5 at an unexpected position aborts the parse. A K28.5 restarts the parse from its own position.
- **Match tracking**
  - A 2-bit `match_cnt`, saturating at 3, counts consecutive `cfg_valid` words equal to the previous word with bit 14 masked.
  - A word that differs resets `match_cnt` to 1.
  - A zero word resets it to 0.
- **FSM.** Priority for restart: `rst`, then `!rx_sync`, then `mr_restart`; any of these forces RESTART.
  - RESTART:
    - outputs: `tx_cfg_en`=1, `tx_cfg_reg`=0x0000.
    - exit: link timer expiry → ABILITY_DETECT.
  - ABILITY_DETECT:
    - output: `tx_cfg_reg`=0x0001.
    - exit: `match_cnt` reaches 3 with a nonzero word → latch the word (bit 14 masked) into `ability`, go to ACK_DETECT.
  - ACK_DETECT:
    - output: `tx_cfg_reg`=0x4001.
    - exit: 3 consecutive words with bit 14 = 1 and masked word == `ability` → COMPLETE_ACK.
    - exit: masked mismatch → ABILITY_DETECT.
    - exit: zero word → RESTART.
  - COMPLETE_ACK:
    - output: `tx_cfg_reg`=0x4001.
    - exit: timer expiry → IDLE_DETECT.
    - exit: mismatch → ABILITY_DETECT.
    - exit: zero word → RESTART.
  - IDLE_DETECT:
    - output: `tx_cfg_en`=0.
    - exit: timer expired and 3 consecutive `idle_valid` with no intervening `cfg_valid` → LINK_OK.
    - exit: any `cfg_valid` → RESTART.
  - LINK_OK:
    - output: `sgmii_autoneg_done`=1.
    - exit: any `cfg_valid` → RESTART.
- `link_speed`, `link_duplex` and `link_up` are loaded from `ability` on entry to LINK_OK and hold until the next LINK_OK entry. They clear on `rst` only.

## Timing

- **Reset values:** state RESTART, `tx_cfg_en`=1, `tx_cfg_reg`=0x0000, `sgmii_autoneg_done`=0, `link_speed`=00, `link_duplex`=0, `link_up`=0, `match_cnt`=0, timer=0.
- **Parser latency:** `cfg_valid` is registered and high in the cycle after the high config byte is presented. `idle_valid` is high in the cycle after the second idle byte.
- **FSM latency:** state updates on the edge where `cfg_valid` is sampled. All outputs decode directly from the state and latch registers, with no extra cycle. Total: the third matching word's high byte at cycle N → new state and outputs at N+2.
- **Link timer:** reloads to 0 on every state entry, including re-entry of RESTART from a restart while already in RESTART. It expires exactly `LINK_TIMER` cycles after entry, then holds expired until the next reload.
- **Restart mid-word:** a restart clears `match_cnt`. The parser is not cleared, so a word already in flight is still delivered but counts from `match_cnt`=0.
- **Simultaneous events:** timer expiry and a zero or mismatching word in the same cycle → the word-driven transition wins.

## Structure

- Shared package `sgmii_pkg` holds:
  - code-group constants: K28_5=8'hBC, D21_5=8'hB5, D2_2=8'h42, D5_6=8'hC5, D16_2=8'h50;
  - config constants: SGMII_CFG_ABIL=16'h0001, SGMII_CFG_ACK_BIT=14;
  - the FSM state enum.
- Sub-module `sgmii_os_parse` (ordered-set parser: `rx_byte`/`rx_is_k` in; `cfg_valid`/`cfg_word`/`idle_valid` out). The FSM, match counter and timer live in the top module.

## Test plan

- **Reset:** `LINK_TIMER`=16, `rx_sync`=1, no RX → `tx_cfg_reg`=0x0000 for 16 cycles, then 0x0001.
- **Full handshake:**
  - Stimulus: after RESTART, send 3× /C/ 0xD801 (1G, full duplex, link up), then 3× 0xD801|0x4000, then /I/.
  - Required: `tx_cfg_reg` goes 0x0001 → 0x4001; `tx_cfg_en`=0 after 16 cycles in COMPLETE_ACK; `sgmii_autoneg_done`=1 after 3 idles; `link_speed`=10, `link_duplex`=1, `link_up`=1.
- **Mismatch:** 2× 0xD801 then 1× 0x9401 in ABILITY_DETECT → no transition; a further 2× 0x9401 → ACK_DETECT with `ability`=0x9401.
- **Zero word:** 0x0000 received in ACK_DETECT → RESTART, `tx_cfg_reg`=0x0000 on the next cycle.
- **Link loss:**
  - In LINK_OK, drop `rx_sync` for 1 cycle → `sgmii_autoneg_done`=0 the next cycle.
  - Separately, inject one /C/ → RESTART.
- **Parser abort:** K28.5, D21.5, then a K character in place of the low byte → no `cfg_valid`; `match_cnt` unchanged.
